hiz_tile_updater: RTL and testbench
===================================

// Module: hiz_tile_updater
// PURPOSE
//  Owns the hierarchical-Z tile store and is the write side of the tile-depth interface.
//  Accepts resolved per-tile depth vectors from late-Z, reduces them and read-modify-writes
//  the per-tile reference depth. Serves lookups whose result drives the reject stage's z_tile_min.
//  Also performs the fast clear of the whole store.
// PARAMETERS
//  PIXELS   16    pixels per tile; must match the reject stage
//  DEPTH_W  24    depth fixed-point width
//  TILES    1024  tiles in the store
//  TILE_AW  $clog2(TILES)  tile index width (derived)
// PORTS
//  clk          in   1                clock
//  rst          in   1                asynchronous, active-high reset
//  clear_req    in   1                request a fast clear of all tiles to clear_depth
//  clear_depth  in   DEPTH_W          clear value; sampled when the clear starts
//  clear_busy   out  1                clear pending or in progress
//  wr_valid     in   1                write-back request valid
//  wr_ready     out  1                write-back accepted on wr_valid & wr_ready
//  wr_tile      in   TILE_AW          tile index
//  wr_zvec      in   PIXELS*DEPTH_W   resolved depths; pixel i at [i*DEPTH_W +: DEPTH_W]
//  wr_mask      in   PIXELS           pixels written by this request
//  lk_valid     in   1                lookup request
//  lk_tile      in   TILE_AW          lookup tile index
//  lk_rvalid    out  1                z_tile_min valid; exactly 1 cycle after lk_valid
//  z_tile_min   out  DEPTH_W          tile reference depth sent to the reject stage
// BEHAVIOUR
//  Reset values
//  - Outputs: clear_busy=1, wr_ready=0, lk_rvalid=0, z_tile_min=0.
//  - FSM enters CLEAR with clear value all-ones, counter=0. Pipeline valid bits clear.
//  - Reset mid-operation abandons any clear or RMW and restarts the clear.
//  FSM states: IDLE, DRAIN, CLEAR.
//  - IDLE -> DRAIN when clear_req=1 and the RMW stage is occupied.
//  - IDLE -> CLEAR when clear_req=1 and the RMW stage is empty; clear_depth is latched here.
//  - DRAIN -> CLEAR once the RMW stage is empty; clear_depth is latched here.
//  - CLEAR writes one tile per cycle, counter 0..TILES-1. -> IDLE after tile TILES-1.
//  - clear_req is ignored outside IDLE.
//  - clear_busy = (state != IDLE). wr_ready = (state == IDLE) & !clear_req.
//  RMW pipeline, full throughput
//  - Stage A (accept): issue a synchronous read of wr_tile. Register the tile index,
//    full = &wr_mask, and zmax = max over the PIXELS entries of wr_zvec.
//  - Stage B (next cycle): old = forwarded value if the previous stage-B write hit the same
//    tile, else RAM data. If full: new = min(old, zmax), written at the end of stage B.
//    If partial: no write, because a partial update cannot lower the tile's farthest depth.
//  - Writes are monotonic: a tile value never increases except by clear.
//  Lookup
//  - Separate synchronous read port. z_tile_min and lk_rvalid are registered.
//  - Write-first: a lookup in the same cycle as a write to the same tile returns the new value.
//  - During DRAIN and CLEAR, lookups return the latched or pending clear value.
//    This is conservative: no rejection against a half-cleared store.
//  - With no lookup, z_tile_min holds its last value.
//  Arithmetic: unsigned compares on DEPTH_W bits. No width growth. Tile index wraps nowhere;
//  an out-of-range index (>=TILES) is dropped silently, with no write and a lookup result of 0.
//  Storage: TILES x DEPTH_W, 2 read ports, 1 write port. Not reset; initialised by the
//  reset-triggered clear.
// STRUCTURE
//  - Shared package hiz_pkg: PIXELS, DEPTH_W, TILES defaults, DEPTH_FAR = all-ones,
//    FSM state enum. Reused by the reject stage.
//  - Sub-module hiz_max_reduce: combinational balanced max tree over PIXELS depths.
//  - Storage is an inferred register/RAM array inside this module.
// TESTING
//  1 Reset release -> clear_busy=1 for exactly 1024 cycles, wr_ready=0 throughout.
//    Then lookup tile 5 -> lk_rvalid next cycle, z_tile_min=24'hFFFFFF.
//  2 Full-mask write tile 3, depths 0x100..0x10F -> lookup tile 3 returns 0x10F.
//    Lookup tile 4 returns 0xFFFFFF.
//  3 Write tile 3, mask 16'h7FFF, depths all 0x001 -> tile 3 stays 0x10F.
//  4 Back-to-back full writes to tile 3, zmax 0x200 then 0x080 -> tile 3 reads 0x10F, then 0x080.
//    Exercises forwarding.
//  5 Lookup tile 3 in the same cycle as a committing write of 0x050 -> z_tile_min=0x050.
//  6 Edge cases:
//    - clear_req with the RMW stage occupied: wr_ready drops the same cycle, the pending write
//      commits, then all tiles read the new clear_depth 0x00ABCD.
//    - rst pulse mid-clear: the clear restarts from tile 0 with 0xFFFFFF.

Source files
------------

// File: rtl/hiz_pkg.sv
// Shared hierarchical-Z definitions: default geometry, far-plane depth and the
// tile-updater FSM encoding. Also imported by the reject stage.
package hiz_pkg;

    localparam int unsigned HIZ_PIXELS  = 16;
    localparam int unsigned HIZ_DEPTH_W = 24;
    localparam int unsigned HIZ_TILES   = 1024;

    localparam logic [HIZ_DEPTH_W-1:0] DEPTH_FAR = '1;

    typedef enum logic [1:0] {
        HIZ_IDLE  = 2'd0,
        HIZ_DRAIN = 2'd1,
        HIZ_CLEAR = 2'd2
    } hiz_state_e;

    // Plain-vector views of the state encoding for the state register.
    localparam logic [1:0] ST_IDLE  = HIZ_IDLE;
    localparam logic [1:0] ST_DRAIN = HIZ_DRAIN;
    localparam logic [1:0] ST_CLEAR = HIZ_CLEAR;

endpackage

// File: rtl/hiz_max_reduce.sv
// Combinational balanced max tree over the PIXELS depths of one tile.
module hiz_max_reduce
    import hiz_pkg::*;
#(
    parameter int unsigned PIXELS  = HIZ_PIXELS,
    parameter int unsigned DEPTH_W = HIZ_DEPTH_W
) (
    input  logic [PIXELS*DEPTH_W-1:0] zvec,
    output logic [DEPTH_W-1:0]        zmax_c
);

    localparam int unsigned LEVELS = $clog2(PIXELS);
    localparam int unsigned NP     = 1 << LEVELS;

    // Leaves padded to a power of two with zero, the identity for max.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [DEPTH_W-1:0] v [NP >> l];
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < NP; j++) begin : g_pix
                if (j < PIXELS) begin : g_real
                    assign v[j] = zvec[j*DEPTH_W +: DEPTH_W];
                end else begin : g_pad
                    assign v[j] = '0;
                end
            end
        end else begin : g_max
            for (genvar j = 0; j < (NP >> l); j++) begin : g_node
                assign v[j] = (g_lvl[l-1].v[2*j] > g_lvl[l-1].v[2*j+1]) ?
                              g_lvl[l-1].v[2*j] : g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign zmax_c = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/hiz_tile_updater.sv
// Hierarchical-Z tile store: folds late-Z write-backs into per-tile reference depths,
// answers reject-stage lookups and runs the fast clear of the whole store.
module hiz_tile_updater
    import hiz_pkg::*;
#(
    parameter int unsigned PIXELS  = HIZ_PIXELS,
    parameter int unsigned DEPTH_W = HIZ_DEPTH_W,
    parameter int unsigned TILES   = HIZ_TILES,
    parameter int unsigned TILE_AW = $clog2(TILES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_req,
    input  logic [DEPTH_W-1:0]          clear_depth,
    output logic                        clear_busy,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [TILE_AW-1:0]          wr_tile,
    input  logic [PIXELS*DEPTH_W-1:0]   wr_zvec,
    input  logic [PIXELS-1:0]           wr_mask,
    input  logic                        lk_valid,
    input  logic [TILE_AW-1:0]          lk_tile,
    output logic                        lk_rvalid,
    output logic [DEPTH_W-1:0]          z_tile_min
);

    function automatic logic tile_ok(input logic [TILE_AW-1:0] idx);
        return {1'b0, idx} < (TILE_AW+1)'(TILES);
    endfunction

    logic [DEPTH_W-1:0] mem [TILES];

    logic [1:0]          state_q, state_d;
    logic [TILE_AW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DEPTH_W-1:0]  clr_val_q, clr_val_d;
    logic                clear_busy_q, clear_busy_d;

    logic                b_valid_q, b_valid_d;
    logic                b_full_q, b_full_d;
    logic [TILE_AW-1:0]  b_tile_q, b_tile_d;
    logic [DEPTH_W-1:0]  b_zmax_q, b_zmax_d;
    logic [DEPTH_W-1:0]  b_rdata_q, b_rdata_d;

    logic                fwd_valid_q, fwd_valid_d;
    logic [TILE_AW-1:0]  fwd_tile_q, fwd_tile_d;
    logic [DEPTH_W-1:0]  fwd_data_q, fwd_data_d;

    logic                lk_rvalid_q, lk_rvalid_d;
    logic [DEPTH_W-1:0]  z_tile_min_q, z_tile_min_d;

    logic                accept;
    logic [DEPTH_W-1:0]  zmax_c;
    logic [DEPTH_W-1:0]  b_old;
    logic [DEPTH_W-1:0]  b_new;
    logic                b_we;
    logic                mem_we;
    logic [TILE_AW-1:0]  mem_waddr;
    logic [DEPTH_W-1:0]  mem_wdata;

    hiz_max_reduce #(
        .PIXELS  (PIXELS),
        .DEPTH_W (DEPTH_W)
    ) u_max (
        .zvec    (wr_zvec),
        .zmax_c  (zmax_c)
    );

    // Write-back is held off the cycle a clear is requested so the drain can finish.
    assign wr_ready = (state_q == ST_IDLE) && !clear_req;
    assign accept   = wr_valid && wr_ready;

    // Stage A captures the request; stage B merges with the (forwarded) old value.
    always_comb begin
        b_valid_d   = accept && tile_ok(wr_tile);
        b_full_d    = &wr_mask;
        b_tile_d    = wr_tile;
        b_zmax_d    = zmax_c;
        b_rdata_d   = mem[wr_tile];

        b_old       = (fwd_valid_q && (fwd_tile_q == b_tile_q)) ? fwd_data_q : b_rdata_q;
        b_new       = (b_old < b_zmax_q) ? b_old : b_zmax_q;
        b_we        = b_valid_q && b_full_q;

        fwd_valid_d = b_we;
        fwd_tile_d  = b_tile_q;
        fwd_data_d  = b_new;

        mem_we      = 1'b0;
        mem_waddr   = b_tile_q;
        mem_wdata   = b_new;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = clr_val_q;
        end else if (b_we) begin
            mem_we    = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_val_d = clr_val_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    if (b_valid_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d   = ST_CLEAR;
                        clr_val_d = clear_depth;
                        clr_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (!b_valid_q) begin
                    state_d   = ST_CLEAR;
                    clr_val_d = clear_depth;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == TILE_AW'(TILES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + TILE_AW'(1);
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_val_d = '1;
                clr_cnt_d = '0;
            end
        endcase
        clear_busy_d = (state_d != ST_IDLE);
    end

    // While a clear is pending or running, report the clear value rather than stale tiles.
    always_comb begin
        lk_rvalid_d  = lk_valid;
        z_tile_min_d = z_tile_min_q;
        if (lk_valid) begin
            if (!tile_ok(lk_tile)) begin
                z_tile_min_d = '0;
            end else if (state_q == ST_DRAIN) begin
                z_tile_min_d = clear_depth;
            end else if (state_q == ST_CLEAR) begin
                z_tile_min_d = clr_val_q;
            end else if (b_we && (b_tile_q == lk_tile)) begin
                z_tile_min_d = b_new;
            end else begin
                z_tile_min_d = mem[lk_tile];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            clr_val_q    <= '1;
            clear_busy_q <= 1'b1;
            b_valid_q    <= 1'b0;
            b_full_q     <= 1'b0;
            b_tile_q     <= '0;
            b_zmax_q     <= '0;
            b_rdata_q    <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_tile_q   <= '0;
            fwd_data_q   <= '0;
            lk_rvalid_q  <= 1'b0;
            z_tile_min_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_val_q    <= clr_val_d;
            clear_busy_q <= clear_busy_d;
            b_valid_q    <= b_valid_d;
            b_full_q     <= b_full_d;
            b_tile_q     <= b_tile_d;
            b_zmax_q     <= b_zmax_d;
            b_rdata_q    <= b_rdata_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_tile_q   <= fwd_tile_d;
            fwd_data_q   <= fwd_data_d;
            lk_rvalid_q  <= lk_rvalid_d;
            z_tile_min_q <= z_tile_min_d;
        end
    end

    // Store contents are not reset; the reset-triggered clear initialises them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign clear_busy = clear_busy_q;
    assign lk_rvalid  = lk_rvalid_q;
    assign z_tile_min = z_tile_min_q;

endmodule

// File: tb/tb_hiz_tile_updater.sv
// Self-checking bench for hiz_tile_updater: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a tile-array model.
module tb_hiz_tile_updater;

    localparam int unsigned PIXELS  = 16;
    localparam int unsigned DEPTH_W = 24;
    localparam int unsigned TILES   = 1024;
    localparam int unsigned TILE_AW = 10;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      clear_req;
    logic [DEPTH_W-1:0]        clear_depth;
    logic                      clear_busy;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [TILE_AW-1:0]        wr_tile;
    logic [PIXELS*DEPTH_W-1:0] wr_zvec;
    logic [PIXELS-1:0]         wr_mask;
    logic                      lk_valid;
    logic [TILE_AW-1:0]        lk_tile;
    logic                      lk_rvalid;
    logic [DEPTH_W-1:0]        z_tile_min;

    hiz_tile_updater dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .clear_depth (clear_depth),
        .clear_busy  (clear_busy),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_tile     (wr_tile),
        .wr_zvec     (wr_zvec),
        .wr_mask     (wr_mask),
        .lk_valid    (lk_valid),
        .lk_tile     (lk_tile),
        .lk_rvalid   (lk_rvalid),
        .z_tile_min  (z_tile_min)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_DRAIN, M_CLEAR} mmode_e;
    mmode_e             m_mode;
    int                 m_left;
    logic [DEPTH_W-1:0] m_cval;
    logic [DEPTH_W-1:0] m_mem [TILES];
    logic               m_pv;
    logic               m_pfull;
    logic [TILE_AW-1:0] m_pt;
    logic [DEPTH_W-1:0] m_pzmax;
    logic               m_acc;
    logic               e_rv;
    logic [DEPTH_W-1:0] e_z;

    function automatic logic [DEPTH_W-1:0] vec_max(input logic [PIXELS*DEPTH_W-1:0] v);
        logic [DEPTH_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(PIXELS); i++)
            if (v[i*DEPTH_W +: DEPTH_W] > m) m = v[i*DEPTH_W +: DEPTH_W];
        return m;
    endfunction

    // A clear is treated as an atomic store overwrite; lookups see the clear value meanwhile.
    task automatic m_start_clear(input logic [DEPTH_W-1:0] v);
        for (int i = 0; i < int'(TILES); i++) m_mem[i] = v;
        m_mode = M_CLEAR;
        m_left = int'(TILES);
        m_cval = v;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_start_clear('1);
            m_pv = 1'b0;
            e_rv = 1'b0;
            e_z  = '0;
        end else begin
            // Write accepted last cycle lands now and is visible to this cycle's lookup.
            if (m_pv && m_pfull && (m_pzmax < m_mem[m_pt])) m_mem[m_pt] = m_pzmax;
            e_rv = lk_valid;
            if (lk_valid) begin
                if (m_mode == M_DRAIN)      e_z = clear_depth;
                else if (m_mode == M_CLEAR) e_z = m_cval;
                else                        e_z = m_mem[lk_tile];
            end
            m_acc = wr_valid && (m_mode == M_IDLE) && !clear_req;
            case (m_mode)
                M_IDLE:  if (clear_req) begin
                             if (m_pv) m_mode = M_DRAIN;
                             else      m_start_clear(clear_depth);
                         end
                M_DRAIN: m_start_clear(clear_depth);
                default: begin
                             m_left--;
                             if (m_left == 0) m_mode = M_IDLE;
                         end
            endcase
            m_pv    = m_acc;
            m_pfull = &wr_mask;
            m_pt    = wr_tile;
            m_pzmax = vec_max(wr_zvec);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("clear_busy", 32'(clear_busy), 32'(m_mode != M_IDLE));
            check("wr_ready",   32'(wr_ready),   32'((m_mode == M_IDLE) && !clear_req));
            check("lk_rvalid",  32'(lk_rvalid),  32'(e_rv));
            check("z_tile_min", 32'(z_tile_min), 32'(e_z));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic make_vec(input logic [DEPTH_W-1:0] zmax, output logic [PIXELS*DEPTH_W-1:0] v);
        int hot;
        hot = int'($urandom_range(0, PIXELS-1));
        for (int i = 0; i < int'(PIXELS); i++)
            v[i*DEPTH_W +: DEPTH_W] = (i == hot) ? zmax : DEPTH_W'($urandom_range(0, 32'(zmax)));
    endtask

    task automatic lookup(input int t, input string name, input logic [DEPTH_W-1:0] exp);
        lk_valid = 1'b1;
        lk_tile  = TILE_AW'(t);
        nxt();
        lk_valid = 1'b0;
        check({name, "_rvalid"}, 32'(lk_rvalid), 32'(1));
        check(name, 32'(z_tile_min), 32'(exp));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (clear_busy === 1'b1 && n < 3000) begin
            n++;
            nxt();
        end
        check(name, 32'(clear_busy), 32'(0));
    endtask

    task automatic count_clear(input string name);
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (clear_busy === 1'b1 && n < 3000) begin
            n++;
            if (wr_ready !== 1'b0) rdy_seen = 1'b1;
            nxt();
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(TILES));
        check({name, "_ready_low"}, 32'(rdy_seen), 32'(0));
    endtask

    logic [PIXELS*DEPTH_W-1:0] v;

    initial begin
        clear_req = 1'b0; clear_depth = '0; wr_valid = 1'b0; wr_tile = '0;
        wr_zvec = '0; wr_mask = '0; lk_valid = 1'b0; lk_tile = '0;
        rst = 1'b1;
        repeat (3) nxt();
        chk_en = 1'b1;
        check("rst_busy", 32'(clear_busy), 32'(1));
        check("rst_z", 32'(z_tile_min), 32'(0));
        rst = 1'b0;

        // 1: reset-triggered clear
        count_clear("t1");
        lookup(5, "t1_tile5", 24'hFFFFFF);

        // 2: full-mask write
        for (int i = 0; i < int'(PIXELS); i++) v[i*DEPTH_W +: DEPTH_W] = DEPTH_W'(24'h100 + i);
        wr_valid = 1'b1; wr_tile = 10'd3; wr_zvec = v; wr_mask = 16'hFFFF;
        nxt();
        wr_valid = 1'b0;
        nxt();
        lookup(3, "t2_tile3", 24'h00010F);
        lookup(4, "t2_tile4", 24'hFFFFFF);

        // 3: partial mask never lowers the tile
        for (int i = 0; i < int'(PIXELS); i++) v[i*DEPTH_W +: DEPTH_W] = 24'h000001;
        wr_valid = 1'b1; wr_tile = 10'd3; wr_zvec = v; wr_mask = 16'h7FFF;
        nxt();
        wr_valid = 1'b0;
        nxt();
        lookup(3, "t3_tile3", 24'h00010F);

        // 4: back-to-back writes to one tile
        make_vec(24'h000200, v);
        wr_valid = 1'b1; wr_tile = 10'd3; wr_zvec = v; wr_mask = 16'hFFFF;
        nxt();
        make_vec(24'h000080, v);
        wr_zvec = v;
        lk_valid = 1'b1; lk_tile = 10'd3;
        nxt();
        check("t4_first", 32'(z_tile_min), 32'h00010F);
        wr_valid = 1'b0;
        nxt();
        lk_valid = 1'b0;
        check("t4_second", 32'(z_tile_min), 32'h000080);

        // 5: lookup coincident with the committing write
        make_vec(24'h000050, v);
        wr_valid = 1'b1; wr_tile = 10'd3; wr_zvec = v; wr_mask = 16'hFFFF;
        nxt();
        wr_valid = 1'b0;
        lookup(3, "t5_write_first", 24'h000050);

        // 6a: clear requested with the RMW stage occupied
        make_vec(24'h000300, v);
        wr_valid = 1'b1; wr_tile = 10'd7; wr_zvec = v; wr_mask = 16'hFFFF;
        nxt();
        wr_valid = 1'b0;
        clear_req = 1'b1; clear_depth = 24'h00ABCD;
        lk_valid = 1'b1; lk_tile = 10'd7;
        #1;
        check("t6_ready_drop", 32'(wr_ready), 32'(0));
        nxt();
        check("t6_pending_commit", 32'(z_tile_min), 32'h000300);
        clear_req = 1'b0;
        nxt();
        lk_valid = 1'b0;
        check("t6_drain_lookup", 32'(z_tile_min), 32'h00ABCD);
        wait_idle("t6_clear_done");
        lookup(7,    "t6_tile7",    24'h00ABCD);
        lookup(0,    "t6_tile0",    24'h00ABCD);
        lookup(1023, "t6_tile1023", 24'h00ABCD);

        // 6b: reset pulse in the middle of a clear
        clear_req = 1'b1; clear_depth = 24'h123456;
        nxt();
        clear_req = 1'b0;
        repeat (20) nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        count_clear("t6b");
        lookup(0,    "t6b_tile0",    24'hFFFFFF);
        lookup(1023, "t6b_tile1023", 24'hFFFFFF);

        // randomized traffic concentrated on a few tiles to hit forwarding and write-first
        for (int c = 0; c < 3000; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_tile  = ($urandom_range(0, 3) == 0) ? TILE_AW'($urandom) : TILE_AW'($urandom_range(0, 7));
            wr_mask  = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            for (int p = 0; p < int'(PIXELS); p++)
                wr_zvec[p*DEPTH_W +: DEPTH_W] = DEPTH_W'($urandom >> $urandom_range(8, 28));
            lk_valid    = ($urandom_range(0, 1) == 1);
            lk_tile     = ($urandom_range(0, 3) == 0) ? TILE_AW'($urandom) : TILE_AW'($urandom_range(0, 7));
            clear_req   = ($urandom_range(0, 699) == 0);
            clear_depth = DEPTH_W'($urandom);
            nxt();
        end
        wr_valid = 1'b0; lk_valid = 1'b0; clear_req = 1'b0;
        wait_idle("rand_drain");
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
